compressed_size_tracker: RTL
============================

COMPRESSED_SIZE_TRACKER -- requirements
Module: compressed_size_tracker

Interface
REQ-001 Parameter ENC_W, default 4, width of the compression-encoding code.
REQ-002 Parameter SIZE_W, default 9, width of one compressed-line size, in bits.
REQ-003 Parameter LINE_BITS, default 256, size of an uncompressed line.
REQ-004 Parameter BUDGET_BITS, default 1024, bit budget of one packed group.
REQ-005 Parameter OFF_W, default 12, width of the offset and total accumulators; OFF_W SHALL be at least clog2(BUDGET_BITS+LINE_BITS)+1.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 enc_valid / enc_ready  in / out  1 / 1  input handshake.
REQ-009 enc_code  in  ENC_W  encoding of the current line.
REQ-010 enc_last  in  1  marks the last line of a group.
REQ-011 out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-012 out_size  out  SIZE_W  decoded line size, in bits.
REQ-013 out_offset  out  OFF_W  bit offset of the line within its group.
REQ-014 out_last, out_ovf  out  1, 1  group end; group budget exceeded.
REQ-015 out_total  out  OFF_W  running group size, including the current line.
REQ-016 cfg_we, cfg_idx, cfg_size  in  1, ENC_W, SIZE_W  size-table write port.

Function
REQ-017 The block SHALL map enc_code to a size using a 2^ENC_W-entry table.
- Defaults: 0->1, 2->96, 3->128, 4->192, 5->96, 6->160, 7->144.
- Every other code -> LINE_BITS (line stored uncompressed).
REQ-018 An input transfer SHALL occur when enc_valid && enc_ready.
REQ-019 enc_ready SHALL equal !out_valid || out_ready (single output register, no bubble).
REQ-020 Outputs SHALL be registered with latency 1 cycle from the input transfer to out_valid.
REQ-021 out_valid SHALL hold, with every output stable, until out_valid && out_ready.
REQ-022 State machine: IDLE (accumulated offset = 0) and ACCUM.
- A transfer with enc_last=0 SHALL move the block to ACCUM.
- A transfer with enc_last=1 SHALL return it to IDLE.
- A single-line group (enc_last=1 from IDLE) SHALL stay in IDLE.
REQ-023 out_offset SHALL equal the accumulated offset before the line; out_total SHALL equal out_offset+out_size; the accumulator SHALL update to out_total, or clear to 0 on enc_last.
REQ-024 out_ovf SHALL be 1 when out_total > BUDGET_BITS and SHALL remain 1 (sticky) for every later line of the same group; it SHALL clear when the group ends.
REQ-025 Arithmetic SHALL be unsigned; the accumulator SHALL saturate at 2^OFF_W-1 rather than wrap.
REQ-026 A simultaneous output drain and new input in the same cycle SHALL be accepted with no lost or duplicated line.

Reset
REQ-027 While rst_n=0, the block SHALL force out_valid=0, out_size=0, out_offset=0, out_total=0, out_last=0, out_ovf=0, state=IDLE, accumulator=0 and sticky overflow=0.
REQ-028 Table contents SHALL return to the defaults on reset.
REQ-029 A reset in mid-group SHALL discard the partial group; the first line after reset SHALL have offset 0.

Configuration
REQ-030 With SIZE_TABLE_PROG_EN defined, cfg_we=1 SHALL write cfg_size to entry cfg_idx at the clock edge.
- The write takes effect for lookups from the next cycle.
- A same-cycle lookup SHALL use the old value.
REQ-031 Without SIZE_TABLE_PROG_EN, the table SHALL be constant defaults and the cfg_* inputs SHALL be ignored.

Verification
REQ-032 Codes 2,3,4(last), out_ready=1 -> sizes 96,128,192; offsets 0,96,224; totals 96,224,416; out_ovf=0; out_last only on the third line.
REQ-033 Six code-9 lines with last on the sixth -> out_ovf first set on the fifth line (total 1280 > 1024), still set on the sixth, and 0 on the next group.
REQ-034 out_ready=0 for 3 cycles with enc_valid=1 -> enc_ready=0 and the output held stable; on release, lines are delivered in order with none lost.
REQ-035 rst_n pulsed low after 2 lines of a group -> out_valid=0 immediately; the next line has offset 0.
REQ-036 SIZE_TABLE_PROG_EN defined, write idx 8 size 64, then code 8 -> out_size=64; without the macro, the same stimulus -> out_size=256.

Source files
------------

// File: rtl/compressed_size_tracker.sv
// Compressed-line size tracker: decodes per-line encodings to sizes and accumulates group offsets.
// Optional macro SIZE_TABLE_PROG_EN makes the size table writable through the cfg_* port.
module compressed_size_tracker #(
  parameter int ENC_W       = 4,
  parameter int SIZE_W      = 9,
  parameter int LINE_BITS   = 256,
  parameter int BUDGET_BITS = 1024,
  parameter int OFF_W       = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enc_valid,
  output logic              enc_ready,
  input  logic [ENC_W-1:0]  enc_code,
  input  logic              enc_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIZE_W-1:0] out_size,
  output logic [OFF_W-1:0]  out_offset,
  output logic              out_last,
  output logic              out_ovf,
  output logic [OFF_W-1:0]  out_total,
  input  logic              cfg_we,
  input  logic [ENC_W-1:0]  cfg_idx,
  input  logic [SIZE_W-1:0] cfg_size
);

  localparam int ENTRIES = 1 << ENC_W;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t             state, state_next;
  logic [OFF_W-1:0]   acc, acc_next;
  logic               sticky, sticky_next;
  logic [SIZE_W-1:0]  line_size;
  logic [OFF_W-1:0]   cur_offset;
  logic [OFF_W-1:0]   line_total;
  logic [OFF_W:0]     sum;
  logic               line_ovf;
  logic               xfer;

  function automatic logic [SIZE_W-1:0] default_size(input int idx);
    case (idx)
      0:       return SIZE_W'(1);
      2:       return SIZE_W'(96);
      3:       return SIZE_W'(128);
      4:       return SIZE_W'(192);
      5:       return SIZE_W'(96);
      6:       return SIZE_W'(160);
      7:       return SIZE_W'(144);
      default: return SIZE_W'(LINE_BITS);
    endcase
  endfunction

`ifdef SIZE_TABLE_PROG_EN
  logic [SIZE_W-1:0] size_tab [ENTRIES];

  // A same-cycle lookup reads the old entry since the write lands on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) size_tab[i] <= default_size(i);
    end else if (cfg_we) begin
      size_tab[cfg_idx] <= cfg_size;
    end
  end

  assign line_size = size_tab[enc_code];
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_we, cfg_idx, cfg_size};
  assign line_size  = default_size(int'(enc_code));
`endif

  assign enc_ready = !out_valid || out_ready;
  assign xfer      = enc_valid && enc_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      sticky <= 1'b0;
    end else begin
      state  <= state_next;
      acc    <= acc_next;
      sticky <= sticky_next;
    end
  end

  // The accumulator saturates instead of wrapping so an oversized group still reads as over budget.
  always_comb begin
    state_next  = state;
    acc_next    = acc;
    sticky_next = sticky;
    cur_offset  = (state == IDLE) ? '0 : acc;
    sum         = {1'b0, cur_offset} + (OFF_W+1)'(line_size);
    line_total  = sum[OFF_W] ? '1 : sum[OFF_W-1:0];
    line_ovf    = sticky || (line_total > OFF_W'(BUDGET_BITS));
    if (xfer) begin
      if (enc_last) begin
        state_next  = IDLE;
        acc_next    = '0;
        sticky_next = 1'b0;
      end else begin
        state_next  = ACCUM;
        acc_next    = line_total;
        sticky_next = line_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_size   <= '0;
      out_offset <= '0;
      out_total  <= '0;
      out_last   <= 1'b0;
      out_ovf    <= 1'b0;
    end else if (xfer) begin
      out_valid  <= 1'b1;
      out_size   <= line_size;
      out_offset <= cur_offset;
      out_total  <= line_total;
      out_last   <= enc_last;
      out_ovf    <= line_ovf;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
